// File: rtl/timer_alarm_sched.sv
// Multi-channel alarm scheduler: N_CH compare channels share one 64-bit
// timer count. Matches queue up as pending bits. A round-robin arbiter
// presents the pending events one at a time on a valid/ack port.

// One alarm channel: deadline/period/mode registers, compare, pending/overrun.
module timer_alarm_ch #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DATA_W-1:0] timer_value,
  input  logic                wr,
  input  logic [1:0]          cfg_addr,
  input  logic [DATA_W-1:0]   cfg_wdata,
  input  logic                deq,
  output logic                pending,
  output logic                ovr
);
  localparam int TW = 2 * DATA_W;

  logic [TW-1:0]     deadline;
  logic [TW-1:0]     period;
  logic [DATA_W-1:0] lo_shadow;
  logic              armed;
  logic              periodic;
  logic              fire;

  // A config write to this channel in the same cycle as a match discards the match.
  assign fire = armed && (timer_value >= deadline) && !wr;

  // Channel state: config writes, match handling, reload and event bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deadline  <= '0;
      period    <= '0;
      lo_shadow <= '0;
      armed     <= 1'b0;
      periodic  <= 1'b0;
      pending   <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      if (deq) pending <= 1'b0;
      if (fire) begin
        // Events coalesce: the pending bit stays set and the loss is flagged.
        pending <= 1'b1;
        if (pending) ovr <= 1'b1;
        if (periodic && (period != '0)) deadline <= deadline + period;
        else                            armed    <= 1'b0;
      end
      if (wr) begin
        case (cfg_addr)
          2'd0: lo_shadow <= cfg_wdata;
          2'd1: deadline  <= {cfg_wdata, lo_shadow};
          2'd2: period    <= {{DATA_W{1'b0}}, cfg_wdata};
          default: begin
            armed    <= cfg_wdata[0];
            periodic <= cfg_wdata[1];
            pending  <= 1'b0;
            ovr      <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

module timer_alarm_sched #(
  parameter int N_CH   = 4,
  parameter int CH_W   = 2,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DATA_W-1:0] timer_value,
  input  logic                cfg_valid,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_addr,
  input  logic [DATA_W-1:0]   cfg_wdata,
  output logic                evt_valid,
  output logic [CH_W-1:0]     evt_ch,
  input  logic                evt_ack,
  output logic                irq,
  output logic [N_CH-1:0]     ovr
);
  typedef enum logic {IDLE, PRESENT} state_t;

  state_t            state, state_next;
  logic [N_CH-1:0]   pending;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   sel;
  logic [CH_W-1:0]   sel_next_ptr;
  logic              any_pend;
  logic              do_sel;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    timer_alarm_ch #(.DATA_W(DATA_W)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .timer_value(timer_value),
      .wr         (cfg_valid && (cfg_ch == CH_W'(c))),
      .cfg_addr   (cfg_addr),
      .cfg_wdata  (cfg_wdata),
      .deq        (do_sel && (sel == CH_W'(c))),
      .pending    (pending[c]),
      .ovr        (ovr[c])
    );
  end

  assign any_pend     = |pending;
  assign sel_next_ptr = (sel == CH_W'(N_CH - 1)) ? '0 : sel + CH_W'(1);
  assign evt_valid    = (state == PRESENT);
  assign irq          = evt_valid;

  // Round-robin pick: first pending channel at or above rr_ptr, wrapping.
  always_comb begin
    int  idx;
    logic found;
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_CH; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && pending[idx]) begin
        found = 1'b1;
        sel   = CH_W'(idx);
      end
    end
  end

  // Event port next state; an ack with more work pending re-arbitrates without a bubble.
  always_comb begin
    state_next = state;
    do_sel     = 1'b0;
    case (state)
      IDLE: begin
        if (any_pend) begin
          do_sel     = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (evt_ack) begin
          if (any_pend) do_sel     = 1'b1;
          else          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Event port registers: state, presented channel and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      evt_ch <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_next;
      if (do_sel) begin
        evt_ch <= sel;
        rr_ptr <= sel_next_ptr;
      end
    end
  end
endmodule

// File: tb/tb_timer_alarm_sched.sv
// Directed bench for timer_alarm_sched: one-shot, periodic, round-robin,
// overrun, config collision and asynchronous reset.
module tb_timer_alarm_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] timer_value;
  logic        cfg_valid;
  logic [1:0]  cfg_ch;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        evt_valid;
  logic [1:0]  evt_ch;
  logic        evt_ack;
  logic        irq;
  logic [3:0]  ovr;

  int n_pass = 0;
  int n_tot  = 0;

  timer_alarm_sched #(.N_CH(4), .CH_W(2), .DATA_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .timer_value(timer_value),
    .cfg_valid  (cfg_valid),
    .cfg_ch     (cfg_ch),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .evt_valid  (evt_valid),
    .evt_ch     (evt_ch),
    .evt_ack    (evt_ack),
    .irq        (irq),
    .ovr        (ovr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] addr, input logic [31:0] data);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_addr  = addr;
    cfg_wdata = data;
    tick();
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; timer_value = '0; cfg_valid = 1'b0; cfg_ch = '0;
    cfg_addr = '0; cfg_wdata = '0; evt_ack = 1'b1;
    tick(); tick();
    chk("rst_valid", evt_valid, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ch", evt_ch, 0);
    chk("rst_ovr", ovr, 0);
    rst = 1'b0;
    tick();

    // ch1 one-shot at 100: a single event seen two cycles after timer hits 100
    cfg(2'd1, 2'd0, 32'd100);
    cfg(2'd1, 2'd1, 32'd0);
    cfg(2'd1, 2'd3, 32'd1);
    for (int v = 90; v <= 115; v++) begin
      chk("oneshot_valid", evt_valid, (v == 102));
      chk("oneshot_irq", irq, (v == 102));
      if (v == 102) chk("oneshot_ch", evt_ch, 1);
      timer_value = 64'(v);
      tick();
    end

    // ch0 periodic: deadline 50, period 20 -> events at 50, 70, 90, then 110
    timer_value = 64'd0;
    cfg(2'd0, 2'd0, 32'd50);
    cfg(2'd0, 2'd1, 32'd0);
    cfg(2'd0, 2'd2, 32'd20);
    cfg(2'd0, 2'd3, 32'd3);
    for (int v = 40; v <= 125; v++) begin
      chk("periodic_valid", evt_valid,
          (v == 52) || (v == 72) || (v == 92) || (v == 112));
      if (v == 112) chk("periodic_ch", evt_ch, 0);
      timer_value = 64'(v);
      tick();
    end
    chk("periodic_ovr", ovr, 0);
    cfg(2'd0, 2'd3, 32'd0);

    // ch1 re-armed with a past deadline fires at once; leaves rr_ptr at 2
    cfg(2'd1, 2'd3, 32'd1);
    chk("past_w0", evt_valid, 0);
    tick();
    chk("past_w1", evt_valid, 0);
    tick();
    chk("past_valid", evt_valid, 1);
    chk("past_ch", evt_ch, 1);
    tick();
    chk("past_idle", evt_valid, 0);

    // round robin: ch0, ch2, ch3 pend together, order 2, 3, 0 back to back
    for (int c = 0; c < 4; c++) begin
      if (c != 1) begin
        cfg(2'(c), 2'd0, 32'd200);
        cfg(2'(c), 2'd1, 32'd0);
        cfg(2'(c), 2'd3, 32'd1);
      end
    end
    chk("rr_pre", evt_valid, 0);
    timer_value = 64'd200;
    tick();
    chk("rr_pend", evt_valid, 0);
    tick();
    chk("rr_v0", evt_valid, 1);
    chk("rr_c0", evt_ch, 2);
    tick();
    chk("rr_v1", evt_valid, 1);
    chk("rr_c1", evt_ch, 3);
    tick();
    chk("rr_v2", evt_valid, 1);
    chk("rr_c2", evt_ch, 0);
    tick();
    chk("rr_end", evt_valid, 0);

    // overrun: ch3 periodic period 5, catch-up matches while unacked
    evt_ack = 1'b0;
    timer_value = 64'd210;
    cfg(2'd3, 2'd2, 32'd5);
    cfg(2'd3, 2'd3, 32'd3);
    chk("ovr_w0", evt_valid, 0);
    tick();
    chk("ovr_w1_valid", evt_valid, 0);
    chk("ovr_w1_ovr", ovr, 0);
    tick();
    chk("ovr_valid", evt_valid, 1);
    chk("ovr_ch", evt_ch, 3);
    chk("ovr_flag", ovr, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ovr_hold_valid", evt_valid, 1);
      chk("ovr_hold_ch", evt_ch, 3);
      chk("ovr_hold_flag", ovr, 4'b1000);
    end
    cfg(2'd3, 2'd3, 32'd3);
    chk("ovr_clr", ovr, 0);
    chk("ovr_clr_keep", evt_valid, 1);
    chk("ovr_clr_keep_ch", evt_ch, 3);
    evt_ack = 1'b1;
    tick();
    chk("ovr_pend_clr", evt_valid, 0);
    tick();
    chk("ovr_pend_clr2", evt_valid, 0);
    cfg(2'd3, 2'd3, 32'd0);

    // collision: CTRL write to ch2 in the cycle ch2 matches wins
    cfg(2'd2, 2'd0, 32'd300);
    cfg(2'd2, 2'd1, 32'd0);
    cfg(2'd2, 2'd2, 32'd10);
    cfg(2'd2, 2'd3, 32'd1);
    timer_value = 64'd300;
    cfg(2'd2, 2'd3, 32'd3);
    timer_value = 64'd250;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("coll_none", evt_valid, 0);
    end
    timer_value = 64'd300;
    tick();
    chk("coll_arm_w", evt_valid, 0);
    tick();
    chk("coll_arm_valid", evt_valid, 1);
    chk("coll_arm_ch", evt_ch, 2);
    timer_value = 64'd310;
    tick();
    chk("coll_per_w", evt_valid, 0);
    tick();
    chk("coll_per_valid", evt_valid, 1);
    chk("coll_per_ch", evt_ch, 2);
    chk("coll_ovr", ovr, 0);
    cfg(2'd2, 2'd3, 32'd0);

    // async reset while presenting with an overrun flagged
    evt_ack = 1'b0;
    cfg(2'd1, 2'd2, 32'd1);
    cfg(2'd1, 2'd3, 32'd3);
    tick();
    tick();
    chk("ar_valid", evt_valid, 1);
    chk("ar_ch", evt_ch, 1);
    chk("ar_ovr", ovr, 4'b0010);
    #2 rst = 1'b1;
    #1;
    chk("ar_now_valid", evt_valid, 0);
    chk("ar_now_irq", irq, 0);
    chk("ar_now_ch", evt_ch, 0);
    chk("ar_now_ovr", ovr, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ar_quiet", evt_valid, 0);
      chk("ar_quiet_ovr", ovr, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
